io_port_bank: RTL and testbench

Parametrised memory-mapped I/O port bank for the 8-bit computer. It replaces the fixed 16-in/16-out port wiring with N_PORTS configurable-width output registers and synchronised input ports. It adds per-input change detection with sticky flags, mask registers and a single interrupt line to the CPU. It sits between the CPU data bus (address / data / write-enable) and the top-level port pins.

---
 rtl/io_port_pkg.sv | 21 ++
 rtl/io_port_sync.sv | 29 ++
 rtl/io_port_bank.sv | 120 ++++++++++++
 tb/tb_io_port_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared constants and helpers for the memory-mapped I/O port bank.
package io_port_pkg;

   localparam int DEF_OUT_BASE  = 'hE0;
   localparam int DEF_IN_BASE   = 'hF0;
   localparam int DEF_CTRL_BASE = 'hD0;

   // Control words are interleaved MASK/FLAG pairs.
   localparam int MASK_OFS    = 0;
   localparam int FLAG_OFS    = 1;
   localparam int CTRL_STRIDE = 2;

   function automatic int calc_nw(input int n_ports, input int data_w);
      return (n_ports + data_w - 1) / data_w;
   endfunction

   function automatic bit ranges_overlap(input int a, input int la, input int b, input int lb);
      return (a < b + lb) && (b < a + la);
   endfunction

endpackage

// File: rtl/io_port_sync.sv
// Two-flop synchroniser for one input port plus a delayed copy for change detection.
module io_port_sync #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] sync_o,
   output logic              chg_o
);

   logic [DATA_W-1:0] s1_q, s2_q, s3_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign sync_o = s2_q;
   assign chg_o  = |(s2_q ^ s3_q);

endmodule

// File: rtl/io_port_bank.sv
// CPU-mapped bank of output registers, synchronised inputs, and
// change flags with mask that combine into a single interrupt.
module io_port_bank
   import io_port_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int N_PORTS   = 16,
   parameter int OUT_BASE  = DEF_OUT_BASE,
   parameter int IN_BASE   = DEF_IN_BASE,
   parameter int CTRL_BASE = DEF_CTRL_BASE
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic                      wr_en,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      hit,
   input  logic [N_PORTS*DATA_W-1:0] port_in,
   output logic [N_PORTS*DATA_W-1:0] port_out,
   output logic                      irq
);

   localparam int NW       = calc_nw(N_PORTS, DATA_W);
   localparam int PAD_W    = NW * DATA_W;
   localparam int CTRL_LEN = CTRL_STRIDE * NW;
   localparam int ASPACE   = 1 << ADDR_W;

   if (N_PORTS < 1 || N_PORTS > 4 * DATA_W ||
       ranges_overlap(OUT_BASE, N_PORTS, IN_BASE, N_PORTS) ||
       ranges_overlap(OUT_BASE, N_PORTS, CTRL_BASE, CTRL_LEN) ||
       ranges_overlap(IN_BASE, N_PORTS, CTRL_BASE, CTRL_LEN) ||
       OUT_BASE + N_PORTS > ASPACE || IN_BASE + N_PORTS > ASPACE ||
       CTRL_BASE + CTRL_LEN > ASPACE) begin : g_param_err
      $error("io_port_bank: bad N_PORTS or overlapping/out-of-space address ranges");
   end

   logic [N_PORTS-1:0][DATA_W-1:0] out_q, out_d;
   logic [N_PORTS-1:0][DATA_W-1:0] sync_v;
   logic [N_PORTS-1:0]             chg;
   logic [N_PORTS-1:0]             mask_q, mask_d, flag_q, flag_d;
   logic [PAD_W-1:0]               mask_pad, flag_pad, mask_wr, clr_pad;
   logic [1:0]                     warm_q, warm_d;
   logic                           armed;

   for (genvar i = 0; i < N_PORTS; i++) begin : g_sync
      io_port_sync #(.DATA_W(DATA_W)) u_sync (
         .clk_i  (clk),
         .rst_ni (reset),
         .d_i    (port_in[i*DATA_W +: DATA_W]),
         .sync_o (sync_v[i]),
         .chg_o  (chg[i])
      );
   end

   // Word view of mask/flag; bits past N_PORTS are hard zero.
   always_comb begin
      mask_pad = '0;
      flag_pad = '0;
      mask_pad[N_PORTS-1:0] = mask_q;
      flag_pad[N_PORTS-1:0] = flag_q;
   end

   always_comb begin
      out_d   = out_q;
      mask_wr = mask_pad;
      clr_pad = '0;
      rd_data = '0;
      hit     = 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (addr == ADDR_W'(OUT_BASE + i)) begin
            hit     = 1'b1;
            rd_data = out_q[i];
            if (wr_en) out_d[i] = wr_data;
         end
         if (addr == ADDR_W'(IN_BASE + i)) begin
            hit     = 1'b1;
            rd_data = sync_v[i];
         end
      end
      for (int j = 0; j < NW; j++) begin
         if (addr == ADDR_W'(CTRL_BASE + CTRL_STRIDE * j + MASK_OFS)) begin
            hit     = 1'b1;
            rd_data = mask_pad[j*DATA_W +: DATA_W];
            if (wr_en) mask_wr[j*DATA_W +: DATA_W] = wr_data;
         end
         if (addr == ADDR_W'(CTRL_BASE + CTRL_STRIDE * j + FLAG_OFS)) begin
            hit     = 1'b1;
            rd_data = flag_pad[j*DATA_W +: DATA_W];
            if (wr_en) clr_pad[j*DATA_W +: DATA_W] = wr_data;
         end
      end
   end

   // Hold off flags until the synchronisers have been filled since reset.
   assign armed  = (warm_q == 2'd3);
   assign warm_d = armed ? warm_q : warm_q + 2'd1;
   assign mask_d = mask_wr[N_PORTS-1:0];
   // A new change wins over a same-edge write-1-to-clear.
   assign flag_d = (flag_q & ~clr_pad[N_PORTS-1:0]) | (chg & {N_PORTS{armed}});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q  <= '0;
         mask_q <= '0;
         flag_q <= '0;
         warm_q <= '0;
      end else begin
         out_q  <= out_d;
         mask_q <= mask_d;
         flag_q <= flag_d;
         warm_q <= warm_d;
      end
   end

   assign port_out = out_q;
   assign irq      = |(flag_q & mask_q);

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with default parameters (16 ports, 8-bit).
module tb_io_port_bank;

   logic         clk;
   logic         reset;
   logic [7:0]   addr;
   logic [7:0]   wr_data;
   logic         wr_en;
   logic [7:0]   rd_data;
   logic         hit;
   logic [127:0] port_in;
   logic [127:0] port_out;
   logic         irq;

   int passed = 0;
   int total  = 0;
   logic [127:0] exp_out;
   logic [7:0]   d;
   logic         h;

   io_port_bank dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .rd_data  (rd_data),
      .hit      (hit),
      .port_in  (port_in),
      .port_out (port_out),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] dv, output logic hv);
      addr = a;
      #1;
      dv = rd_data;
      hv = hit;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] dv);
      addr    = a;
      wr_data = dv;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
      addr    = 8'h10;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      wr_en = 1'b0;
      addr  = 8'h10;
      wr_data = 8'h00;
      for (int i = 0; i < 16; i++)
         port_in[i*8 +: 8] = (i == 2 || i == 10) ? 8'h00 : 8'h30 + 8'(i);
      tick(); tick(); tick();
      total++; if (port_out !== 128'h0) $display("FAIL rst_port_out got %h exp 0", port_out); else passed++;
      total++; if (irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq); else passed++;
      rd(8'hD1, d, h);
      total++; if (d !== 8'h00) $display("FAIL rst_flag0 got %h exp 00", d); else passed++;
      reset = 1'b1;
      tick(); tick(); tick(); tick();
      rd(8'hD1, d, h);
      total++; if (d !== 8'h00) $display("FAIL warm_flag0 got %h exp 00", d); else passed++;
      rd(8'hD3, d, h);
      total++; if (d !== 8'h00) $display("FAIL warm_flag1 got %h exp 00", d); else passed++;
      rd(8'hF5, d, h);
      total++; if (d !== 8'h35 || h !== 1'b1) $display("FAIL warm_in5 got %h/%b exp 35/1", d, h); else passed++;
   endtask

   task automatic test_out_write();
      exp_out = '0;
      wr(8'hE3, 8'hA5);
      exp_out[3*8 +: 8] = 8'hA5;
      total++; if (port_out !== exp_out) $display("FAIL out_wr got %h exp %h", port_out, exp_out); else passed++;
      rd(8'hE3, d, h);
      total++; if (d !== 8'hA5 || h !== 1'b1) $display("FAIL out_rd got %h/%b exp a5/1", d, h); else passed++;
      wr(8'hF3, 8'h5A);
      total++; if (port_out !== exp_out) $display("FAIL in_wr_ignored got %h exp %h", port_out, exp_out); else passed++;
      rd(8'hF3, d, h);
      total++; if (d !== 8'h33) $display("FAIL in_rd3 got %h exp 33", d); else passed++;
      rd(8'hD3, d, h);
      total++; if (d !== 8'h00) $display("FAIL in_wr_noflag got %h exp 00", d); else passed++;
   endtask

   task automatic test_change_irq();
      wr(8'hD2, 8'h04);
      port_in[10*8 +: 8] = 8'h01;
      tick();
      rd(8'hFA, d, h);
      total++; if (d !== 8'h00) $display("FAIL chg_s1_only got %h exp 00", d); else passed++;
      tick();
      rd(8'hFA, d, h);
      total++; if (d !== 8'h01) $display("FAIL chg_in_rd got %h exp 01", d); else passed++;
      rd(8'hD3, d, h);
      total++; if (d !== 8'h00 || irq !== 1'b0) $display("FAIL chg_early got %h/%b exp 00/0", d, irq); else passed++;
      tick();
      rd(8'hD3, d, h);
      total++; if (d !== 8'h04) $display("FAIL chg_flag got %h exp 04", d); else passed++;
      total++; if (irq !== 1'b1) $display("FAIL chg_irq got %b exp 1", irq); else passed++;
   endtask

   task automatic test_w1c();
      wr(8'hD3, 8'h04);
      rd(8'hD3, d, h);
      total++; if (d !== 8'h00 || irq !== 1'b0) $display("FAIL w1c_clear got %h/%b exp 00/0", d, irq); else passed++;
      port_in[10*8 +: 8] = 8'h00;
      tick(); tick();
      rd(8'hD3, d, h);
      total++; if (d !== 8'h00) $display("FAIL w1c_preset got %h exp 00", d); else passed++;
      wr(8'hD3, 8'h04);
      rd(8'hD3, d, h);
      total++; if (d !== 8'h04 || irq !== 1'b1) $display("FAIL w1c_set_wins got %h/%b exp 04/1", d, irq); else passed++;
      wr(8'hD3, 8'h04);
      rd(8'hD3, d, h);
      total++; if (d !== 8'h00 || irq !== 1'b0) $display("FAIL w1c_reclear got %h/%b exp 00/0", d, irq); else passed++;
   endtask

   task automatic test_mask_late();
      port_in[2*8 +: 8] = 8'h80;
      tick(); tick(); tick();
      rd(8'hD1, d, h);
      total++; if (d !== 8'h04) $display("FAIL unmasked_flag got %h exp 04", d); else passed++;
      total++; if (irq !== 1'b0) $display("FAIL unmasked_irq got %b exp 0", irq); else passed++;
      wr(8'hD0, 8'h04);
      total++; if (irq !== 1'b1) $display("FAIL late_mask_irq got %b exp 1", irq); else passed++;
      rd(8'hD0, d, h);
      total++; if (d !== 8'h04) $display("FAIL mask0_rd got %h exp 04", d); else passed++;
      wr(8'hD0, 8'h00);
      total++; if (irq !== 1'b0) $display("FAIL mask_off_irq got %b exp 0", irq); else passed++;
      wr(8'hD0, 8'h04);
   endtask

   task automatic test_unmapped();
      rd(8'h10, d, h);
      total++; if (d !== 8'h00 || h !== 1'b0) $display("FAIL unmap_10 got %h/%b exp 00/0", d, h); else passed++;
      rd(8'hD4, d, h);
      total++; if (d !== 8'h00 || h !== 1'b0) $display("FAIL unmap_d4 got %h/%b exp 00/0", d, h); else passed++;
      rd(8'hCF, d, h);
      total++; if (d !== 8'h00 || h !== 1'b0) $display("FAIL unmap_cf got %h/%b exp 00/0", d, h); else passed++;
      rd(8'hEF, d, h);
      total++; if (d !== 8'h00 || h !== 1'b1) $display("FAIL out15_edge got %h/%b exp 00/1", d, h); else passed++;
      wr(8'h10, 8'hFF);
      total++; if (port_out !== exp_out) $display("FAIL unmap_wr got %h exp %h", port_out, exp_out); else passed++;
   endtask

   task automatic test_reset_mid();
      total++; if (irq !== 1'b1 || port_out !== exp_out) $display("FAIL pre_rst got %b/%h exp 1/%h", irq, port_out, exp_out); else passed++;
      reset = 1'b0;
      #1;
      total++; if (port_out !== 128'h0) $display("FAIL mid_rst_out got %h exp 0", port_out); else passed++;
      total++; if (irq !== 1'b0) $display("FAIL mid_rst_irq got %b exp 0", irq); else passed++;
      rd(8'hD1, d, h);
      total++; if (d !== 8'h00) $display("FAIL mid_rst_flag got %h exp 00", d); else passed++;
      rd(8'hD0, d, h);
      total++; if (d !== 8'h00) $display("FAIL mid_rst_mask got %h exp 00", d); else passed++;
      rd(8'hF2, d, h);
      total++; if (d !== 8'h00) $display("FAIL mid_rst_sync got %h exp 00", d); else passed++;
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_out_write();
      test_change_irq();
      test_w1c();
      test_mask_late();
      test_unmapped();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
